// File: rtl/oldest2_issue_sched.sv
// ---------------------------------------------------------------------------
// oldest2_issue_sched
//
// Circular issue queue that grants the two oldest valid & ready entries each
// cycle. Entries are allocated at the tail and woken up by index. Issued
// entries leave holes, and head skips forward over holes that sit in front of
// the oldest surviving entry.
//
// Optional feature macro: OLDEST2_ISSUE_SCHED_BYPASS_EN
//   When defined, an allocation that is already ready goes straight out on
//   port 0 in the same cycle, provided no queued entry is eligible.
//   When undefined, issue outputs depend only on registered state.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_i                     drop every entry, pointers back to 0
//   alloc_valid_i/ready_o/data_i  allocate handshake (fires on valid & ready)
//   alloc_rdy_i                 operands of the allocated entry already present
//   wakeup_valid_i/idx_i        mark one entry ready
//   issN_valid_o/ready_i/data_o/idx_o  issue ports, N = 0 (oldest), 1 (next)
//   count_o                     tail - head (occupied span, holes included)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends on the matching ready.
// ---------------------------------------------------------------------------
module oldest2_issue_sched #(
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic [DATA_WIDTH-1:0] alloc_data_i,
    input  logic                  alloc_rdy_i,
    input  logic                  wakeup_valid_i,
    input  logic [IDX_WIDTH-1:0]  wakeup_idx_i,
    output logic                  iss0_valid_o,
    input  logic                  iss0_ready_i,
    output logic [DATA_WIDTH-1:0] iss0_data_o,
    output logic [IDX_WIDTH-1:0]  iss0_idx_o,
    output logic                  iss1_valid_o,
    input  logic                  iss1_ready_i,
    output logic [DATA_WIDTH-1:0] iss1_data_o,
    output logic [IDX_WIDTH-1:0]  iss1_idx_o,
    output logic [IDX_WIDTH:0]    count_o
);

    localparam int PW = IDX_WIDTH + 1;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;

    logic                  full;
    logic [IDX_WIDTH-1:0]  tail_idx;
    logic                  g0_found, g1_found;
    logic [IDX_WIDTH-1:0]  g0_idx, g1_idx;
    logic                  alloc_fire, alloc_write;
    logic                  iss0_fire, iss1_fire;
    logic                  bypass_taken;

    assign tail_idx      = tail_q[IDX_WIDTH-1:0];
    assign count_o       = tail_q - head_q;
    assign full          = (head_q ^ tail_q) == {1'b1, {IDX_WIDTH{1'b0}}};
    assign alloc_ready_o = ~full;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;

    // Age-ordered scan from head: first two valid & ready entries win.
    always_comb begin
        logic [IDX_WIDTH-1:0] idx;
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q[IDX_WIDTH-1:0] + IDX_WIDTH'(k);
            if (valid_q[idx] && ready_q[idx]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0_idx   = idx;
                end else if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = idx;
                end
            end
        end
    end

`ifdef OLDEST2_ISSUE_SCHED_BYPASS_EN
    logic bypass;
    assign bypass       = ~g0_found & alloc_valid_i & alloc_rdy_i & alloc_ready_o;
    assign bypass_taken = bypass & iss0_ready_i;

    always_comb begin
        iss0_valid_o = g0_found | bypass;
        iss0_idx_o   = '0;
        iss0_data_o  = '0;
        if (g0_found) begin
            iss0_idx_o  = g0_idx;
            iss0_data_o = data_q[g0_idx];
        end else if (bypass) begin
            iss0_idx_o  = tail_idx;
            iss0_data_o = alloc_data_i;
        end
    end
`else
    assign bypass_taken = 1'b0;
    assign iss0_valid_o = g0_found;
    assign iss0_idx_o   = g0_found ? g0_idx : '0;
    assign iss0_data_o  = g0_found ? data_q[g0_idx] : '0;
`endif

    assign iss1_valid_o = g1_found;
    assign iss1_idx_o   = g1_found ? g1_idx : '0;
    assign iss1_data_o  = g1_found ? data_q[g1_idx] : '0;

    // Bypassed issue never occupied a slot, so only queued grants free entries.
    assign iss0_fire   = g0_found & iss0_ready_i;
    assign iss1_fire   = g1_found & iss1_ready_i;
    assign alloc_write = alloc_fire & ~bypass_taken & ~flush_i;

    always_comb begin
        logic [PW-1:0] span;
        logic          hit;
        logic [IDX_WIDTH-1:0] idx;
        valid_d = valid_q;
        ready_d = ready_q;
        tail_d  = tail_q;
        head_d  = head_q;
        span    = '0;
        hit     = 1'b0;
        idx     = '0;

        // Wakeup only touches live entries; applied before frees so a freed
        // slot never keeps a stale ready bit.
        if (wakeup_valid_i && valid_q[wakeup_idx_i]) begin
            ready_d[wakeup_idx_i] = 1'b1;
        end
        if (iss0_fire) begin
            valid_d[g0_idx] = 1'b0;
            ready_d[g0_idx] = 1'b0;
        end
        if (iss1_fire) begin
            valid_d[g1_idx] = 1'b0;
            ready_d[g1_idx] = 1'b0;
        end
        if (alloc_write) begin
            valid_d[tail_idx] = 1'b1;
            ready_d[tail_idx] = alloc_rdy_i |
                                (wakeup_valid_i && (wakeup_idx_i == tail_idx));
            tail_d = tail_q + PW'(1);
        end

        // Head moves to the oldest survivor, or meets tail when none remain.
        span   = tail_d - head_q;
        head_d = tail_d;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q[IDX_WIDTH-1:0] + IDX_WIDTH'(k);
            if (!hit && (PW'(k) < span) && valid_d[idx]) begin
                hit    = 1'b1;
                head_d = head_q + PW'(k);
            end
        end

        if (flush_i) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload needs no reset: outputs are masked by the grant bits.
    always_ff @(posedge clk) begin
        if (alloc_write) begin
            data_q[tail_idx] <= alloc_data_i;
        end
    end

endmodule

// File: tb/tb_oldest2_issue_sched.sv
module tb_oldest2_issue_sched;
    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [31:0] alloc_data_i;
    logic        alloc_rdy_i;
    logic        wakeup_valid_i;
    logic [3:0]  wakeup_idx_i;
    logic        iss0_valid_o;
    logic        iss0_ready_i;
    logic [31:0] iss0_data_o;
    logic [3:0]  iss0_idx_o;
    logic        iss1_valid_o;
    logic        iss1_ready_i;
    logic [31:0] iss1_data_o;
    logic [3:0]  iss1_idx_o;
    logic [4:0]  count_o;

    int n_cmp = 0;
    int n_err = 0;

    oldest2_issue_sched #(.DEPTH(16), .IDX_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_data_i   (alloc_data_i),
        .alloc_rdy_i    (alloc_rdy_i),
        .wakeup_valid_i (wakeup_valid_i),
        .wakeup_idx_i   (wakeup_idx_i),
        .iss0_valid_o   (iss0_valid_o),
        .iss0_ready_i   (iss0_ready_i),
        .iss0_data_o    (iss0_data_o),
        .iss0_idx_o     (iss0_idx_o),
        .iss1_valid_o   (iss1_valid_o),
        .iss1_ready_i   (iss1_ready_i),
        .iss1_data_o    (iss1_data_o),
        .iss1_idx_o     (iss1_idx_o),
        .count_o        (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // checking
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic clr_inputs();
        flush_i        = 1'b0;
        alloc_valid_i  = 1'b0;
        alloc_data_i   = '0;
        alloc_rdy_i    = 1'b0;
        wakeup_valid_i = 1'b0;
        wakeup_idx_i   = '0;
        iss0_ready_i   = 1'b0;
        iss1_ready_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic rdy, input logic [31:0] d);
        alloc_valid_i = 1'b1;
        alloc_rdy_i   = rdy;
        alloc_data_i  = d;
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_count", count_o, 0);
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_iss0_valid", iss0_valid_o, 0);
        check("rst_iss1_valid", iss1_valid_o, 0);
        check("rst_iss0_data", iss0_data_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three ready allocs: A,B issue together, C next cycle.
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 32'hA0 + 32'(i));
            tick();
        end
        clr_inputs();
        #1;
        check("abc_iss0_idx", iss0_idx_o, 0);
        check("abc_iss0_data", iss0_data_o, 32'hA0);
        check("abc_iss1_valid", iss1_valid_o, 1);
        check("abc_iss1_idx", iss1_idx_o, 1);
        check("abc_iss1_data", iss1_data_o, 32'hA1);
        check("abc_count", count_o, 3);
        iss0_ready_i = 1'b1;
        iss1_ready_i = 1'b1;
        tick();
        #1;
        check("c_iss0_idx", iss0_idx_o, 2);
        check("c_iss0_data", iss0_data_o, 32'hA2);
        check("c_iss1_valid", iss1_valid_o, 0);
        check("c_iss1_data", iss1_data_o, 0);
        check("c_count", count_o, 1);
        tick();
        #1;
        check("abc_done_count", count_o, 0);
        check("abc_done_iss0", iss0_valid_o, 0);
        clr_inputs();

        // Move head from 3 to 14: 11 ready allocs, then drain two per cycle.
        for (int i = 0; i < 11; i++) begin
            alloc(1'b1, 32'(i));
            tick();
        end
        clr_inputs();
        iss0_ready_i = 1'b1;
        iss1_ready_i = 1'b1;
        repeat (6) tick();
        clr_inputs();
        #1;
        check("pre_wrap_head", dut.head_q, 14);
        check("pre_wrap_count", count_o, 0);

        // Wrap: entries 14 (not ready), 15, 0 (ready).
        alloc(1'b0, 32'hB0);
        tick();
        alloc(1'b1, 32'hB1);
        tick();
        alloc(1'b1, 32'hB2);
        tick();
        clr_inputs();
        #1;
        check("wrap_iss0_idx", iss0_idx_o, 15);
        check("wrap_iss0_data", iss0_data_o, 32'hB1);
        check("wrap_iss1_idx", iss1_idx_o, 0);
        check("wrap_iss1_data", iss1_data_o, 32'hB2);
        check("wrap_count", count_o, 3);
        iss0_ready_i = 1'b1;
        iss1_ready_i = 1'b1;
        tick();
        clr_inputs();
        #1;
        check("wrap_iss0_after", iss0_valid_o, 0);
        check("wrap_iss1_after", iss1_valid_o, 0);
        check("wrap_head_stays", dut.head_q, 14);
        check("wrap_count_after", count_o, 3);
        wakeup_valid_i = 1'b1;
        wakeup_idx_i   = 4'd14;
        tick();
        clr_inputs();
        #1;
        check("wake14_valid", iss0_valid_o, 1);
        check("wake14_idx", iss0_idx_o, 14);
        check("wake14_data", iss0_data_o, 32'hB0);
        iss0_ready_i = 1'b1;
        tick();
        clr_inputs();
        #1;
        check("wrap_drain_head", dut.head_q, 17);
        check("wrap_drain_count", count_o, 0);

        // Flush together with alloc and wakeup.
        alloc(1'b0, 32'hD0);
        tick();
        alloc(1'b1, 32'hD1);
        flush_i        = 1'b1;
        wakeup_valid_i = 1'b1;
        wakeup_idx_i   = 4'd1;
        tick();
        clr_inputs();
        #1;
        check("flush_count", count_o, 0);
        check("flush_iss0", iss0_valid_o, 0);
        check("flush_iss1", iss1_valid_o, 0);
        check("flush_head", dut.head_q, 0);
        check("flush_tail", dut.tail_q, 0);

        // Fill with 16 non-ready entries, then wake index 3.
        for (int i = 0; i < 16; i++) begin
            alloc(1'b0, 32'h100 + 32'(i));
            tick();
        end
        clr_inputs();
        #1;
        check("full_alloc_ready", alloc_ready_o, 0);
        check("full_count", count_o, 16);
        check("full_iss0", iss0_valid_o, 0);
        wakeup_valid_i = 1'b1;
        wakeup_idx_i   = 4'd3;
        tick();
        clr_inputs();
        #1;
        check("wake3_valid", iss0_valid_o, 1);
        check("wake3_idx", iss0_idx_o, 3);
        check("wake3_data", iss0_data_o, 32'h103);
        check("wake3_iss1", iss1_valid_o, 0);
        iss0_ready_i = 1'b1;
        tick();
        clr_inputs();
        #1;
        check("hole3_iss0", iss0_valid_o, 0);
        check("hole3_alloc_ready", alloc_ready_o, 0);
        check("hole3_count", count_o, 16);
        check("hole3_head", dut.head_q, 0);

        // Independent ports: only port 1 accepts.
        wakeup_valid_i = 1'b1;
        wakeup_idx_i   = 4'd5;
        tick();
        wakeup_idx_i   = 4'd7;
        tick();
        clr_inputs();
        #1;
        check("two_iss0_idx", iss0_idx_o, 5);
        check("two_iss1_idx", iss1_idx_o, 7);
        check("two_iss1_data", iss1_data_o, 32'h107);
        iss1_ready_i = 1'b1;
        tick();
        clr_inputs();
        #1;
        check("hold_iss0_valid", iss0_valid_o, 1);
        check("hold_iss0_idx", iss0_idx_o, 5);
        check("hold_iss0_data", iss0_data_o, 32'h105);
        check("hold_iss1_valid", iss1_valid_o, 0);
        check("hold_iss1_idx", iss1_idx_o, 0);
        check("hold_iss1_data", iss1_data_o, 0);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", count_o, 0);
        check("async_rst_iss0", iss0_valid_o, 0);
        check("async_rst_alloc_ready", alloc_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        check("post_rst_iss0", iss0_valid_o, 0);
        check("post_rst_count", count_o, 0);

        // Ready alloc into an empty queue with port 0 accepting.
        alloc(1'b1, 32'hC0);
        iss0_ready_i = 1'b1;
        #1;
`ifdef OLDEST2_ISSUE_SCHED_BYPASS_EN
        check("byp_iss0_valid", iss0_valid_o, 1);
        check("byp_iss0_idx", iss0_idx_o, 0);
        check("byp_iss0_data", iss0_data_o, 32'hC0);
        tick();
        clr_inputs();
        #1;
        check("byp_count", count_o, 0);
        check("byp_iss0_after", iss0_valid_o, 0);
`else
        check("nobyp_iss0_same", iss0_valid_o, 0);
        tick();
        clr_inputs();
        #1;
        check("nobyp_count", count_o, 1);
        check("nobyp_iss0_next", iss0_valid_o, 1);
        check("nobyp_iss0_data", iss0_data_o, 32'hC0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
